// File: rtl/au_pkg.sv
// au_pkg: shared width, fixed-point, opcode and FSM-state definitions for the AU sequencer
package au_pkg;
  localparam int W    = 24;
  localparam int FRAC = 14;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MAC = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_WBACK} state_t;
endpackage

// File: rtl/au_seq_if.sv
// au_seq_if: command, AU start/done and response signals between the sequencer and its environment
interface au_seq_if import au_pkg::*; #(parameter int AW = 4);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_dst;
  logic [AW-1:0] cmd_ra;
  logic [AW-1:0] cmd_rb;
  logic [AW-1:0] cmd_rc;
  logic          au_start;
  logic [1:0]    au_ctl_d;
  logic [W-1:0]  au_R;
  logic [W-1:0]  au_S;
  logic [W-1:0]  au_I;
  logic [W-1:0]  au_result;
  logic          au_done;
  logic          rsp_valid;
  logic [W-1:0]  rsp_data;
  modport master (
    input  cmd_valid, cmd_op, cmd_dst, cmd_ra, cmd_rb, cmd_rc, au_result, au_done,
    output cmd_ready, au_start, au_ctl_d, au_R, au_S, au_I, rsp_valid, rsp_data
  );
  modport slave (
    output cmd_valid, cmd_op, cmd_dst, cmd_ra, cmd_rb, cmd_rc, au_result, au_done,
    input  cmd_ready, au_start, au_ctl_d, au_R, au_S, au_I, rsp_valid, rsp_data
  );
endinterface

// File: rtl/au_seq_regfile.sv
// au_seq_regfile: NREG x W register file, one write port (AU writeback beats host), operand and host read ports
module au_seq_regfile import au_pkg::*; #(
  parameter  int NREG = 16,
  localparam int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic [W-1:0]  wb_data,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW-1:0] ra,
  input  logic [AW-1:0] rb,
  input  logic [AW-1:0] rc,
  output logic [W-1:0]  qa,
  output logic [W-1:0]  qb,
  output logic [W-1:0]  qc,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);
  logic [NREG-1:0][W-1:0] mem;
  assign qa      = mem[ra];
  assign qb      = mem[rb];
  assign qc      = mem[rc];
  assign rd_data = mem[rd_addr];
  // single write port: a same-cycle AU writeback overrides the host write
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) mem <= '0;
    else if (wb_en) mem[wb_addr] <= wb_data;
    else if (wr_en) mem[wr_addr] <= wr_data;
endmodule

// File: rtl/au_seq.sv
// au_seq: AU command initiator; fetches operands, drives start, waits for done, writes back (optional AU_SEQ_TIMEOUT_EN watchdog)
module au_seq import au_pkg::*; #(
`ifdef AU_SEQ_TIMEOUT_EN
  parameter  int TIMEOUT = 63,
`endif
  parameter  int NREG = 16,
  localparam int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  au_seq_if.master      bus,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data,
  output logic          seq_err
);
  state_t        state;
  logic [AW-1:0] dst;
  logic [W-1:0]  op_r, op_s, op_i;
  au_seq_regfile #(.NREG(NREG)) u_rf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wb_en   (state == S_WBACK),
    .wb_addr (dst),
    .wb_data (bus.rsp_data),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .ra      (bus.cmd_ra),
    .rb      (bus.cmd_rb),
    .rc      (bus.cmd_rc),
    .qa      (op_r),
    .qb      (op_s),
    .qc      (op_i),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );
`ifdef AU_SEQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wcnt;
`else
  assign seq_err = 1'b0;
`endif
  // sequencer FSM; operands are snapshotted at accept so src==dst commands are safe
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state         <= S_IDLE;
      dst           <= '0;
      bus.cmd_ready <= 1'b0;
      bus.au_start  <= 1'b0;
      bus.au_ctl_d  <= '0;
      bus.au_R      <= '0;
      bus.au_S      <= '0;
      bus.au_I      <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
`ifdef AU_SEQ_TIMEOUT_EN
      wcnt          <= '0;
      seq_err       <= 1'b0;
`endif
    end else begin
      bus.au_start  <= 1'b0;
      bus.rsp_valid <= 1'b0;
      case (state)
        S_IDLE:
          if (bus.cmd_valid && bus.cmd_ready) begin
            state         <= S_ISSUE;
            dst           <= bus.cmd_dst;
            bus.cmd_ready <= 1'b0;
            bus.au_start  <= 1'b1;
            bus.au_ctl_d  <= bus.cmd_op;
            bus.au_R      <= op_r;
            bus.au_S      <= op_s;
            bus.au_I      <= (bus.cmd_op == OP_MAC) ? op_i : '0;
          end else bus.cmd_ready <= 1'b1;
        S_ISSUE: begin
          state <= S_WAIT;
`ifdef AU_SEQ_TIMEOUT_EN
          wcnt  <= '0;
`endif
        end
        S_WAIT:
          if (bus.au_done) begin
            state         <= S_WBACK;
            bus.rsp_valid <= 1'b1;
            bus.rsp_data  <= bus.au_result;
          end
`ifdef AU_SEQ_TIMEOUT_EN
          else if (wcnt == CW'(TIMEOUT - 1)) begin
            state         <= S_IDLE;
            bus.cmd_ready <= 1'b1;
            seq_err       <= 1'b1;
          end else wcnt <= wcnt + 1'b1;
`endif
        default: begin
          state         <= S_IDLE;
          bus.cmd_ready <= 1'b1;
        end
      endcase
    end
endmodule
